trp_ctrl: RTL and testbench

- Sequencing controller that drives the transpose FIFO's write/read request interface (ffinit/ffwreq/ffrreq/ffwdata, ffrdata/ffrvld).
- Accepts a BUFFD-row tile on a valid/ready input stream and fills the FIFO.
- Then drains transposed columns to a valid/ready output stream with backpressure.
- Sits between the upstream row producer and the downstream consumer in the transpose datapath; one tile in flight at a time.

---
 rtl/trp_ctrl.sv | 148 ++++++++++++++
 tb/tb_trp_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trp_ctrl.sv
// Transpose FIFO sequencer: fills one BUFFD-row tile from the input stream, then
// drains transposed columns to the output stream under valid/ready backpressure.
//   state | meaning
//   IDLE  | waiting for start, mode checked here
//   INIT  | one-cycle FIFO pointer clear
//   FILL  | accept BUFFD rows into the FIFO
//   DRAIN | issue reads, present columns downstream
//   FIN   | one-cycle done pulse
module trp_ctrl #(
  parameter int BUFFD = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           mode_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [BUFFD*8-1:0]   in_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [BUFFD*8-1:0]   out_data,
  output logic                 out_last,
  output logic [1:0]           mode,
  output logic                 ffinit,
  output logic                 ffwreq,
  output logic [BUFFD*8-1:0]   ffwdata,
  output logic                 ffrreq,
  input  logic [BUFFD*8-1:0]   ffrdata,
  input  logic                 ffrvld
);

  localparam int CW = $clog2(BUFFD) + 1;
  localparam logic [CW-1:0] LIM_8   = CW'(BUFFD);
  localparam logic [CW-1:0] LIM_32  = CW'(BUFFD / 4);
  localparam logic [CW-1:0] WR_LAST = CW'(BUFFD - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {IDLE, INIT, FILL, DRAIN, FIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic          out_vld_q, out_vld_d;
  logic          err_q, err_d;
  logic          ffrreq_q;

  logic [CW-1:0] rlim;
  logic          mode_ok;
  logic          rd_issue;
  logic          beat_acc;
  logic          is_last;
  logic          wr_acc;

  assign mode_ok  = (mode_in == 2'b01) || (mode_in == 2'b10);
  assign rlim     = (mode_q == 2'b10) ? LIM_32 : LIM_8;
  // A new read may only be issued when the output register is empty or being emptied.
  assign rd_issue = (state_q == DRAIN) && (rcnt_q < rlim) && (!out_vld_q || out_rdy);
  assign beat_acc = out_vld_q && out_rdy;
  assign is_last  = out_vld_q && (ocnt_q == rlim - ONE);
  assign wr_acc   = (state_q == FILL) && in_vld;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    ocnt_d    = ocnt_q;
    out_vld_d = out_vld_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode_ok) begin
            mode_d  = mode_in;
            state_d = INIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      INIT: begin
        wcnt_d  = '0;
        rcnt_d  = '0;
        ocnt_d  = '0;
        state_d = FILL;
      end
      FILL: begin
        if (wr_acc) begin
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == WR_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_issue) rcnt_d = rcnt_q + ONE;
        if (beat_acc) ocnt_d = ocnt_q + ONE;
        out_vld_d = rd_issue || (out_vld_q && !out_rdy);
        if (beat_acc && is_last) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      ocnt_q    <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      ffrreq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      ocnt_q    <= ocnt_d;
      out_vld_q <= out_vld_d;
      err_q     <= err_d;
      ffrreq_q  <= rd_issue;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign in_rdy   = (state_q == FILL);
  assign ffwreq   = wr_acc;
  assign ffwdata  = in_data;
  assign ffinit   = (state_q == INIT);
  assign ffrreq   = rd_issue;
  assign out_vld  = out_vld_q;
  assign out_data = ffrdata;
  assign out_last = is_last;
  assign mode     = mode_q;

  // The FIFO answers every read exactly one cycle later.
  a_rvld: assert property (@(posedge clk) disable iff (!reset_n) ffrvld == ffrreq_q)
    else $error("ffrvld does not follow the registered ffrreq");

endmodule

// File: tb/tb_trp_ctrl.sv
// Bench for trp_ctrl: behavioural transpose FIFO plus tile-level scoreboard.
module tb_trp_ctrl;
  localparam int BUFFD = 8;
  localparam int DW    = BUFFD * 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode_in = 2'b00;
  logic          busy, done, err;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] in_data = '0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    mode;
  logic          ffinit, ffwreq, ffrreq;
  logic [DW-1:0] ffwdata;
  logic [DW-1:0] ffrdata = '0;
  logic          ffrvld = 1'b0;

  always #5 clk = ~clk;

  trp_ctrl #(.BUFFD(BUFFD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_in(mode_in),
    .busy(busy), .done(done), .err(err),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .mode(mode), .ffinit(ffinit), .ffwreq(ffwreq), .ffwdata(ffwdata),
    .ffrreq(ffrreq), .ffrdata(ffrdata), .ffrvld(ffrvld)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transpose FIFO: stores rows, returns columns in read order.
  logic [7:0] fmem [BUFFD][BUFFD];
  int fwp = 0;
  int frp = 0;

  function automatic logic [DW-1:0] fifo_col(input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < BUFFD; i++)
      v[i*8 +: 8] = (mode == 2'b10) ? fmem[i/4][4*k + i%4] : fmem[i][k];
    return v;
  endfunction

  always @(posedge clk) begin
    ffrvld <= reset_n ? ffrreq : 1'b0;
    if (ffinit) begin
      fwp = 0;
      frp = 0;
    end else begin
      if (ffwreq && fwp < BUFFD) begin
        for (int c = 0; c < BUFFD; c++) fmem[fwp][c] = ffwdata[c*8 +: 8];
        fwp++;
      end
      if (ffrreq && frp < BUFFD) begin
        ffrdata <= fifo_col(frp);
        frp++;
      end
    end
  end

  // Observation at the falling edge.
  logic [DW-1:0] bq[$];
  bit            lq[$];
  int            bcq[$];
  int ffinit_cnt, done_cnt, err_cnt, err_wide, order_err, stall_req_err, stable_err;
  int last_wr_cyc, done_cyc;
  bit init_seen, prev_stall, prev_err;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (ffinit) begin ffinit_cnt++; init_seen = 1; end
    if (ffwreq) begin
      if (!init_seen) order_err++;
      last_wr_cyc = cyc;
    end
    if (out_vld && !out_rdy && ffrreq) stall_req_err++;
    if (prev_stall && out_vld && out_data !== prev_data) stable_err++;
    prev_stall = out_vld && !out_rdy;
    prev_data  = out_data;
    if (out_vld && out_rdy) begin
      bq.push_back(out_data);
      lq.push_back(out_last);
      bcq.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin
      err_cnt++;
      if (prev_err) err_wide++;
    end
    prev_err = err;
  end

  task automatic clear_mon();
    bq.delete(); lq.delete(); bcq.delete();
    ffinit_cnt = 0; done_cnt = 0; err_cnt = 0; err_wide = 0;
    order_err = 0; stall_req_err = 0; stable_err = 0;
    last_wr_cyc = 0; done_cyc = 0;
    init_seen = 0; prev_stall = 0; prev_err = 0;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Downstream ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: begin out_rdy = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
      2: out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b1;
    endcase
  end

  logic [7:0] tx_rows [BUFFD][BUFFD];

  task automatic rows_pattern();
    for (int r = 0; r < BUFFD; r++)
      for (int c = 0; c < BUFFD; c++) tx_rows[r][c] = 8'(8*r + c);
  endtask

  task automatic rows_random();
    for (int r = 0; r < BUFFD; r++)
      for (int c = 0; c < BUFFD; c++) tx_rows[r][c] = 8'($urandom_range(0, 255));
  endtask

  // Expected column k: mode 01 is a byte transpose; mode 10 regroups 4-byte words.
  function automatic logic [DW-1:0] exp_beat(input logic [1:0] m, input int k);
    logic [DW-1:0] v;
    for (int i = 0; i < BUFFD; i++)
      v[i*8 +: 8] = (m == 2'b10) ? tx_rows[i/4][4*k + i%4] : tx_rows[i][k];
    return v;
  endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic start_tile(input logic [1:0] m);
    clear_mon();
    start = 1'b1;
    mode_in = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rows(input int gap_max, input bit extra_start);
    int gap;
    int guard;
    bit acc;
    for (int r = 0; r < BUFFD; r++) begin
      gap = $urandom_range(0, gap_max);
      in_vld = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_vld = 1'b1;
      for (int c = 0; c < BUFFD; c++) in_data[c*8 +: 8] = tx_rows[r][c];
      if (extra_start && r == 3) begin start = 1'b1; mode_in = 2'b10; end
      acc = 0;
      guard = 0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = in_rdy;
        @(posedge clk); #1;
        guard++;
      end
      start = 1'b0;
      if (!acc) chk("row_accept_timeout", 0, 1);
    end
    in_vld = 1'b0;
  endtask

  task automatic finish_tile(input logic [1:0] m);
    int nb;
    int guard;
    nb = (m == 2'b10) ? BUFFD / 4 : BUFFD;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin @(posedge clk); #1; guard++; end
    chk("done_seen", DW'(done_cnt != 0), 1);
    chk("done_width", DW'(done), 0);
    chk("beat_count", DW'(bq.size()), DW'(nb));
    for (int k = 0; k < nb && k < bq.size(); k++) begin
      chk($sformatf("beat_data[%0d]", k), bq[k], exp_beat(m, k));
      chk($sformatf("beat_last[%0d]", k), DW'(lq[k]), DW'(k == nb - 1));
    end
    if (bcq.size() > 0) chk("done_after_last", DW'(done_cyc), DW'(bcq[bcq.size()-1] + 1));
    chk("ffinit_count", DW'(ffinit_cnt), 1);
    chk("init_before_write", DW'(order_err), 0);
    chk("no_read_in_stall", DW'(stall_req_err), 0);
    chk("stall_data_stable", DW'(stable_err), 0);
    if (rdy_mode == 0 && bq.size() == nb) begin
      chk("throughput", DW'(bcq[nb-1] - bcq[0]), DW'(nb - 1));
      chk("first_beat_latency", DW'(bcq[0] - last_wr_cyc), 2);
    end
  endtask

  task automatic run_tile(input logic [1:0] m, input int gap_max, input bit extra_start);
    start_tile(m);
    send_rows(gap_max, extra_start);
    finish_tile(m);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, DW'(busy), 0);
    chk({pfx, "_done"}, DW'(done), 0);
    chk({pfx, "_err"}, DW'(err), 0);
    chk({pfx, "_out_vld"}, DW'(out_vld), 0);
    chk({pfx, "_ffinit"}, DW'(ffinit), 0);
    chk({pfx, "_ffrreq"}, DW'(ffrreq), 0);
    chk({pfx, "_mode"}, DW'(mode), 0);
    chk({pfx, "_in_rdy"}, DW'(in_rdy), 0);
  endtask

  initial begin
    int guard;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed pattern tiles, the second starting the cycle after done.
    rdy_mode = 0;
    rows_pattern();
    run_tile(2'b01, 0, 0);
    run_tile(2'b10, 0, 0);

    // Backpressure 1,0,0,1 with input gaps.
    rdy_mode = 1;
    rdy_ph = 0;
    rows_random();
    run_tile(2'b01, 3, 0);

    // Illegal modes.
    rdy_mode = 0;
    clear_mon();
    start = 1'b1; mode_in = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse_11", DW'(err), 1);
    chk("err_busy", DW'(busy), 0);
    @(posedge clk); #1;
    chk("err_clear", DW'(err), 0);
    start = 1'b1; mode_in = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse_00", DW'(err), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("err_count", DW'(err_cnt), 2);
    chk("err_width", DW'(err_wide), 0);
    chk("err_no_ffinit", DW'(ffinit_cnt), 0);
    chk("err_idle", DW'(busy), 0);

    // Start during FILL must be ignored; random backpressure.
    rdy_mode = 2;
    rows_random();
    run_tile(2'b01, 2, 1);
    rows_random();
    run_tile(2'b10, 2, 0);

    // Reset in the middle of the drain.
    rdy_mode = 0;
    rows_random();
    start_tile(2'b01);
    send_rows(0, 0);
    guard = 0;
    while (bq.size() < 3 && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("mid_drain_reached", DW'(bq.size() >= 3), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("mid_rst_no_done", DW'(done_cnt), 0);

    // Refill after reset, then a back-to-back tile with fresh data.
    rows_random();
    run_tile(2'b01, 1, 0);
    rows_random();
    run_tile(2'b01, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
